// File: rtl/uart_avalon_host.sv
// Avalon-MM initiator for the RS232 UART s1 port: polls status, drains RX bytes
// into a one-entry holding register, feeds TX bytes from a small FIFO, clears errors.
`timescale 1ns/1ps
module uart_avalon_host #(
  parameter int TX_DEPTH = 4,
  parameter int ERRW     = 8
) (
  input  logic            clk_clk,
  input  logic            reset_reset_n,
  output logic [2:0]      uart_address,
  output logic            uart_begintransfer,
  output logic            uart_chipselect,
  output logic            uart_read_n,
  output logic            uart_write_n,
  output logic [15:0]     uart_writedata,
  input  logic [15:0]     uart_readdata,
  input  logic [7:0]      tx_data,
  input  logic            tx_valid,
  output logic            tx_ready,
  output logic [7:0]      rx_data,
  output logic            rx_valid,
  input  logic            rx_ready,
  output logic [ERRW-1:0] err_count
);

  localparam int PW = $clog2(TX_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {IDLE, POLL, CLR, RD_RX, WR_TX} state_t;

  state_t          state_q, state_d;
  logic            phase_q, phase_d;   // 0 = cycle A, 1 = cycle B
  logic [7:0]      fifo_mem [TX_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic [ERRW-1:0] err_q, err_d;
  logic            push, pop;
  logic            unused_status;

  assign unused_status = ^{uart_readdata[15:9], uart_readdata[5:0]};

  assign tx_ready  = (count_q < CW'(TX_DEPTH));
  assign push      = tx_valid & tx_ready;
  assign pop       = (state_q == WR_TX) & phase_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign err_count = err_q;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q    <= IDLE;
      phase_q    <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      err_q      <= err_d;
    end
  end

  // FIFO storage carries no reset; only the pointers and count define its contents.
  always_ff @(posedge clk_clk) begin
    if (push) fifo_mem[wr_ptr_q] <= tx_data;
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q & ~rx_ready;
    err_d      = err_q;
    case (state_q)
      IDLE: begin
        state_d = POLL;
        phase_d = 1'b0;
      end
      default: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          state_d = IDLE;
          if (state_q == POLL) begin
            // Decision uses the pre-poll rx_valid and FIFO count, not this cycle's updates.
            if (uart_readdata[8]) begin
              state_d = CLR;
              if (err_q != '1) err_d = err_q + ERRW'(1);
            end else if (uart_readdata[7] && !rx_valid_q) begin
              state_d = RD_RX;
            end else if (uart_readdata[6] && (count_q != '0)) begin
              state_d = WR_TX;
            end
          end
          if (state_q == RD_RX) begin
            rx_data_d  = uart_readdata[7:0];
            rx_valid_d = 1'b1;
          end
        end
      end
    endcase
  end

  always_comb begin
    uart_chipselect    = (state_q != IDLE);
    uart_begintransfer = (state_q != IDLE) & ~phase_q;
    uart_read_n        = ~((state_q == POLL) | (state_q == RD_RX));
    uart_write_n       = ~((state_q == CLR) | (state_q == WR_TX));
    uart_address       = 3'd0;
    uart_writedata     = 16'h0000;
    case (state_q)
      POLL, CLR: uart_address = 3'd2;
      WR_TX: begin
        uart_address   = 3'd1;
        uart_writedata = {8'h00, fifo_mem[rd_ptr_q]};
      end
      default: uart_address = 3'd0;
    endcase
  end

endmodule

// File: tb/tb_uart_avalon_host.sv
// Directed bench for uart_avalon_host with a combinational UART register model
// and a bus monitor that logs every access and counts protocol violations.
`timescale 1ns/1ps
module tb_uart_avalon_host;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  uart_address;
  logic        uart_begintransfer, uart_chipselect, uart_read_n, uart_write_n;
  logic [15:0] uart_writedata, uart_readdata;
  logic [7:0]  tx_data = 8'h00;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready = 1'b0;
  logic [7:0]  err_count;

  logic [15:0] status_reg = 16'h0000;
  logic [15:0] rxdata_reg = 16'h0000;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int proto_err = 0;

  typedef struct {
    logic [2:0]  addr;
    logic        wr;
    logic [15:0] data;
    int          cyc;
  } acc_t;
  acc_t log_q[$];

  logic       prev_a = 1'b0;
  logic [2:0] prev_addr = 3'd0;

  always #5 clk = ~clk;

  uart_avalon_host #(.TX_DEPTH(4), .ERRW(8)) dut (
    .clk_clk           (clk),
    .reset_reset_n     (rst_n),
    .uart_address      (uart_address),
    .uart_begintransfer(uart_begintransfer),
    .uart_chipselect   (uart_chipselect),
    .uart_read_n       (uart_read_n),
    .uart_write_n      (uart_write_n),
    .uart_writedata    (uart_writedata),
    .uart_readdata     (uart_readdata),
    .tx_data           (tx_data),
    .tx_valid          (tx_valid),
    .tx_ready          (tx_ready),
    .rx_data           (rx_data),
    .rx_valid          (rx_valid),
    .rx_ready          (rx_ready),
    .err_count         (err_count)
  );

  assign uart_readdata = (uart_address == 3'd2) ? status_reg :
                         (uart_address == 3'd0) ? rxdata_reg : 16'h0000;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit bus_bad();
    bit b = 1'b0;
    if (!uart_chipselect && (!uart_read_n || !uart_write_n || uart_begintransfer)) b = 1'b1;
    if (uart_chipselect && (uart_read_n == uart_write_n)) b = 1'b1;
    if (uart_chipselect && uart_begintransfer && prev_a) b = 1'b1;
    if (uart_chipselect && !uart_begintransfer && !(prev_a && uart_address == prev_addr)) b = 1'b1;
    if (prev_a && !(uart_chipselect && !uart_begintransfer)) b = 1'b1;
    if (uart_write_n && uart_writedata != 16'h0000) b = 1'b1;
    return b;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_a <= 1'b0;
    end else begin
      proto_err <= proto_err + int'(bus_bad());
      prev_a    <= uart_chipselect & uart_begintransfer;
      prev_addr <= uart_address;
      if (uart_chipselect && uart_begintransfer) begin
        log_q.push_back('{uart_address, ~uart_write_n,
                          uart_write_n ? uart_readdata : uart_writedata, cyc});
        $display("[%0d] access addr=%0d %s data=%04h", cyc, uart_address,
                 uart_write_n ? "rd" : "wr", uart_write_n ? uart_readdata : uart_writedata);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s = %0h", tag, obs);
    end
  endtask

  function automatic int count_acc(input logic [2:0] a, input logic wr);
    int n = 0;
    foreach (log_q[i]) if (log_q[i].addr == a && log_q[i].wr == wr) n++;
    return n;
  endfunction

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic push(input logic [7:0] b);
    int k = 0;
    @(negedge clk);
    while (!tx_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!tx_ready) check("push_timeout", 0, 1);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle_gap();
    int k = 0;
    @(negedge clk);
    while (uart_chipselect && k < 20) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic wait_rx_valid(input string tag);
    int k = 0;
    while (!rx_valid && k < 30) begin
      @(negedge clk);
      k++;
    end
    check(tag, rx_valid, 1);
  endtask

  task automatic release_and_check_first_poll();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_idle_cs", uart_chipselect, 0);
    @(negedge clk);
    check("rel_poll_cs", uart_chipselect, 1);
    check("rel_poll_addr", uart_address, 2);
    check("rel_poll_bt", uart_begintransfer, 1);
    check("rel_poll_rd", uart_read_n, 0);
  endtask

  initial begin
    int bad_gap, k, w_first;
    acc_t w[$];

    // Power-on reset
    cycles(2);
    check("rst_cs", uart_chipselect, 0);
    check("rst_bt", uart_begintransfer, 0);
    check("rst_rdn", uart_read_n, 1);
    check("rst_wrn", uart_write_n, 1);
    check("rst_addr", uart_address, 0);
    check("rst_wd", uart_writedata, 0);
    check("rst_rxv", rx_valid, 0);
    check("rst_rxd", rx_data, 0);
    check("rst_err", err_count, 0);
    check("rst_txr", tx_ready, 1);
    release_and_check_first_poll();

    // Idle polling with an all-zero status
    wait_idle_gap();
    log_q.delete();
    cycles(30);
    check("idle_polls", log_q.size(), 10);
    check("idle_addr2_reads", count_acc(3'd2, 1'b0), 10);
    bad_gap = 0;
    for (int i = 1; i < log_q.size(); i++)
      if (log_q[i].cyc - log_q[i-1].cyc != 3) bad_gap++;
    check("idle_period", bad_gap, 0);

    // RX read
    wait_idle_gap();
    log_q.delete();
    status_reg = 16'h0080;
    rxdata_reg = 16'h0041;
    wait_rx_valid("rx1_valid");
    check("rx1_data", rx_data, 8'h41);
    check("rx1_reads", count_acc(3'd0, 1'b0), 1);

    // Blocked RX must not stall TX
    status_reg = 16'h00C0;
    rxdata_reg = 16'h0042;
    log_q.delete();
    push(8'h5A);
    cycles(20);
    check("rxblk_no_rdrx", count_acc(3'd0, 1'b0), 0);
    check("rxblk_wr_cnt", count_acc(3'd1, 1'b1), 1);
    w = log_q.find(x) with (x.addr == 3'd1 && x.wr);
    if (w.size() > 0) check("rxblk_wr_data", w[0].data, 16'h005A);
    check("rxblk_hold", rx_data, 8'h41);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    check("rx_popped", rx_valid, 0);
    wait_rx_valid("rx2_valid");
    check("rx2_data", rx_data, 8'h42);
    status_reg = 16'h0000;
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    cycles(6);
    check("rx_drained", rx_valid, 0);

    // TX ordering and FIFO full
    push(8'h11);
    push(8'h22);
    push(8'h33);
    check("tx3_ready", tx_ready, 1);
    push(8'h44);
    check("tx4_full", tx_ready, 0);
    wait_idle_gap();
    log_q.delete();
    status_reg = 16'h0040;
    k = 0;
    while (!tx_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("tx_ready_rise", tx_ready, 1);
    check("tx_ready_after_1st", count_acc(3'd1, 1'b1), 1);
    k = 0;
    while (count_acc(3'd1, 1'b1) < 4 && k < 60) begin
      @(negedge clk);
      k++;
    end
    w = log_q.find(x) with (x.addr == 3'd1 && x.wr);
    check("tx_wr_cnt", w.size(), 4);
    if (w.size() >= 4) begin
      check("tx_wr0", w[0].data, 16'h0011);
      check("tx_wr1", w[1].data, 16'h0022);
      check("tx_wr2", w[2].data, 16'h0033);
      check("tx_wr3", w[3].data, 16'h0044);
    end

    // Error clear has priority over RX and TX
    status_reg = 16'h0000;
    push(8'h77);
    wait_idle_gap();
    log_q.delete();
    status_reg = 16'h01C8;
    k = 0;
    while (log_q.size() < 2 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("err_nacc", log_q.size(), 2);
    if (log_q.size() >= 2) begin
      check("err_clr_wr", log_q[1].wr, 1);
      check("err_clr_addr", log_q[1].addr, 2);
      check("err_clr_data", log_q[1].data, 16'h0000);
    end
    check("err_cnt1", err_count, 1);
    cycles(1600);
    check("err_sat", err_count, 8'hFF);
    check("err_no_rx", rx_valid, 0);

    // Simultaneous push and pop at 3 entries
    status_reg = 16'h0000;
    push(8'hA1);
    push(8'hA2);
    wait_idle_gap();
    log_q.delete();
    status_reg = 16'h0040;
    k = 0;
    while (!(uart_chipselect && !uart_begintransfer && uart_address == 3'd1) && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("sim_found_wrB", uart_address, 1);
    tx_data  = 8'hA3;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    status_reg = 16'h0000;
    check("sim_occ3_ready", tx_ready, 1);
    push(8'hA4);
    check("sim_occ4_full", tx_ready, 0);
    status_reg = 16'h0040;
    k = 0;
    while (count_acc(3'd1, 1'b1) < 5 && k < 60) begin
      @(negedge clk);
      k++;
    end
    w = log_q.find(x) with (x.addr == 3'd1 && x.wr);
    check("sim_wr_cnt", w.size(), 5);
    if (w.size() >= 5) begin
      check("sim_wr0", w[0].data, 16'h0077);
      check("sim_wr1", w[1].data, 16'h00A1);
      check("sim_wr2", w[2].data, 16'h00A2);
      check("sim_wr3", w[3].data, 16'h00A3);
      check("sim_wr4", w[4].data, 16'h00A4);
    end
    check("bus_protocol", proto_err, 0);

    // Reset in cycle A of RD_RX with a full FIFO
    status_reg = 16'h0000;
    cycles(4);
    push(8'h01);
    push(8'h02);
    push(8'h03);
    push(8'h04);
    check("mr_full", tx_ready, 0);
    status_reg = 16'h0080;
    rxdata_reg = 16'h0055;
    k = 0;
    @(negedge clk);
    while (!(uart_chipselect && uart_begintransfer && uart_address == 3'd0) && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("mr_rdrx_a", uart_read_n, 0);
    rst_n = 1'b0;
    #1;
    check("mr_cs", uart_chipselect, 0);
    check("mr_rdn", uart_read_n, 1);
    check("mr_wrn", uart_write_n, 1);
    check("mr_rxv", rx_valid, 0);
    check("mr_txr", tx_ready, 1);
    check("mr_err", err_count, 0);
    status_reg = 16'h0000;
    cycles(2);
    release_and_check_first_poll();
    cycles(10);
    check("mr_no_retry", rx_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_avalon_host.md
Name: uart_avalon_host

Overview:
- Avalon-MM initiator that drives the s1 slave port of the system's RS232 UART core, converting it into byte streams for user logic.
- Polls the UART status register, reads received bytes into an RX output stream, and writes bytes from an internal TX FIFO to the UART.
- Clears UART error conditions and counts them.
- Sits in user logic next to the generated system, wired directly to the exported uart_0_s1_* signals.

Parameters:
TX_DEPTH, 4, TX FIFO entries; power of two, minimum 2
ERRW, 8, width of the saturating error counter

Ports:
clk_clk  in  1  system clock, same clock as the UART core
reset_reset_n  in  1  asynchronous active-low reset
uart_address  out  3  s1 register address: 0 rxdata, 1 txdata, 2 status
uart_begintransfer  out  1  high on the first cycle of each access only
uart_chipselect  out  1  high for both cycles of an access
uart_read_n  out  1  active-low read strobe
uart_write_n  out  1  active-low write strobe
uart_writedata  out  16  write data
uart_readdata  in  16  read data from the UART
tx_data  in  8  byte to transmit
tx_valid  in  1  tx_data is valid
tx_ready  out  1  TX FIFO not full; a push occurs when tx_valid and tx_ready are both high
rx_data  out  8  received byte
rx_valid  out  1  rx_data is valid; held until accepted
rx_ready  in  1  sink accepts; a pop occurs when rx_valid and rx_ready are both high
err_count  out  ERRW  number of UART error events, saturating

Behaviour:
- Reset (asynchronous, takes effect mid-access):
  - uart_chipselect=0, uart_begintransfer=0, uart_read_n=1, uart_write_n=1, uart_address=0, uart_writedata=0.
  - rx_valid=0, rx_data=0, err_count=0; TX FIFO emptied so tx_ready=1; FSM goes to IDLE.
  - Any in-flight access is abandoned and not retried.
- Bus access, fixed at 2 cycles:
  - Cycle A: chipselect=1, the strobe for the access low, begintransfer=1.
  - Cycle B: same as A but begintransfer=0.
  - Reads sample uart_readdata at the end of cycle B.
  - Next cycle: chipselect=0, strobes high, begintransfer=0.
  - address and writedata are stable across A and B.
- States: IDLE, POLL (read addr 2), CLR (write addr 2, data 0), RD_RX (read addr 0), WR_TX (write addr 1, data {8'h00, FIFO head}).
- IDLE always goes to POLL next cycle; it is a 1-cycle gap with no access.
- At the end of POLL cycle B, with the captured status S, next state by priority:
  1. S[8] (E) = 1: go to CLR; err_count increments, saturating at all ones.
  2. S[7] (RRDY) = 1 and rx_valid = 0: go to RD_RX.
  3. S[6] (TRDY) = 1 and FIFO not empty: go to WR_TX.
  4. Otherwise: go to IDLE.
- CLR, RD_RX and WR_TX each return to IDLE after cycle B.
- Idle poll period is 3 cycles.
- RD_RX: at the end of cycle B, rx_data <= readdata[7:0] and rx_valid <= 1. rx_valid is visible on the following cycle.
- RX holding register is a single entry. While rx_valid=1, RRDY is ignored, so a blocked RX does not stall TX.
- WR_TX: the FIFO head is popped at the end of cycle B.
- TX FIFO:
  - Push when tx_valid & tx_ready.
  - Push and pop in the same cycle are both performed; occupancy is unchanged.
  - tx_ready = (occupancy < TX_DEPTH), combinational from the registered count.
  - When full, a push is impossible even if a pop occurs that cycle (tx_ready is already 0).
  - Pointers wrap modulo TX_DEPTH.
- Byte order: TX bytes go out in push order; RX bytes are presented in read order.
- A TX byte pushed during a POLL is not eligible for that POLL's decision unless the FIFO was already non-empty.
- Unused status bits are ignored. uart_writedata is 0 outside write accesses.

Test Plan:
- Reset: drive reset_reset_n low mid-access (cycle A of RD_RX) -> strobes high, chipselect 0, rx_valid 0, tx_ready 1 in the same cycle; after release, the first access is POLL at addr 2 starting 1 cycle after IDLE.
- Idle polling: status model returns 16'h0000 -> repeating pattern of IDLE, read addr 2 for 2 cycles, with begintransfer high only in cycle A; no other addresses ever accessed.
- RX path with backpressure:
  - Model status 16'h0080 and rxdata 16'h0041 -> RD_RX at addr 0; rx_data=8'h41, rx_valid=1.
  - With rx_ready=0 and status 16'h00C0 plus a queued TX byte -> WR_TX proceeds and no second RD_RX occurs until rx_ready accepts 8'h41.
- TX ordering and full: push 8'h11, 8'h22, 8'h33, 8'h44 with TRDY=0 -> tx_ready falls after the 4th push; set TRDY=1 -> writes to addr 1 with data 16'h0011, 16'h0022, 16'h0033, 16'h0044 in order, and tx_ready rises after the first pop.
- Error handling: status 16'h01C8 (E, RRDY, TRDY, ROE) -> CLR write to addr 2 of 16'h0000 chosen over RX/TX, err_count 0 -> 1; force 300 error polls with ERRW=8 -> err_count stays at 255.
- Simultaneous push and pop: FIFO at 3 entries, push on the same cycle as the WR_TX pop -> occupancy stays 3 and byte order is preserved.
